painterengine_gpu_sync_fifo: RTL and testbench



---
 rtl/painterengine_gpu_sync_fifo_pkg.sv | 36 +++
 rtl/painterengine_gpu_fifo_ram.sv | 28 ++
 rtl/painterengine_gpu_sync_fifo.sv | 151 +++++++++++++++
 tb/tb_painterengine_gpu_sync_fifo.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/painterengine_gpu_sync_fifo_pkg.sv
// Shared definitions for the GPU sync FIFO slice: default depth, the
// ceil-log2 helper used to size pointers and counters, and the packed
// flag bundle with its reset value.
// Optional feature macro: PAINTERENGINE_GPU_FIFO_ERR_FLAGS_EN (sticky
// overflow/underflow outputs). It is off by default; define it on the
// tool command line to enable.
// `define PAINTERENGINE_GPU_FIFO_ERR_FLAGS_EN
package painterengine_gpu_sync_fifo_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 256;

  // Smallest n such that 2**n >= value (value >= 1).
  function automatic int clogb2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      res = res + 1;
    end
    return res;
  endfunction

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RESET = '{
    full:         1'b0,
    almost_full:  1'b0,
    empty:        1'b1,
    almost_empty: 1'b1
  };

endpackage

// File: rtl/painterengine_gpu_fifo_ram.sv
// Storage array for the GPU sync FIFO: one synchronous write port and one
// asynchronous read port so the head word falls through without latency.
// Contents are deliberately not reset.
module painterengine_gpu_fifo_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port: store the pushed word on the rising edge.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/painterengine_gpu_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count,
// programmable almost-full/almost-empty levels, synchronous flush and a
// peak-occupancy watermark. Pointer, count, flag and peak state live here;
// storage is in painterengine_gpu_fifo_ram.
// Optional feature macro: PAINTERENGINE_GPU_FIFO_ERR_FLAGS_EN adds sticky
// o_wire_overflow / o_wire_underflow outputs.
module painterengine_gpu_sync_fifo
  import painterengine_gpu_sync_fifo_pkg::*;
#(
  parameter  int PARAM_DATA_WIDTH = 32,
  parameter  int PARAM_FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int ADDR_W           = clogb2(PARAM_FIFO_DEPTH),
  localparam int CNT_W            = ADDR_W + 1
) (
  input  logic                        i_wire_clock,
  input  logic                        i_wire_resetn,
  input  logic                        i_wire_flush,
  input  logic                        i_wire_write,
  input  logic [PARAM_DATA_WIDTH-1:0] i_wire_data_in,
  input  logic                        i_wire_read,
  output logic [PARAM_DATA_WIDTH-1:0] o_wire_data_out,
  output logic                        o_wire_valid,
  input  logic [CNT_W-1:0]            i_wire_almost_full_threshold,
  input  logic [CNT_W-1:0]            i_wire_almost_empty_threshold,
  output logic [CNT_W-1:0]            o_wire_data_count,
  output logic [CNT_W-1:0]            o_wire_peak_count,
  output logic                        o_wire_full,
  output logic                        o_wire_almost_full,
  output logic                        o_wire_empty,
`ifdef PAINTERENGINE_GPU_FIFO_ERR_FLAGS_EN
  output logic                        o_wire_almost_empty,
  output logic                        o_wire_overflow,
  output logic                        o_wire_underflow
`else
  output logic                        o_wire_almost_empty
`endif
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(PARAM_FIFO_DEPTH);

  logic [ADDR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [CNT_W-1:0]            peak_q, peak_d;
  fifo_flags_t                 flags_q, flags_d;
  logic [CNT_W-1:0]            count_next;
  logic                        push_ok;
  logic                        pop_ok;
  logic [PARAM_DATA_WIDTH-1:0] ram_rdata;

  // Acceptance uses the registered flags from before the edge, so a full
  // FIFO rejects a write even when a read frees a slot in the same cycle.
  assign push_ok = i_wire_write && !flags_q.full;
  assign pop_ok  = i_wire_read  && !flags_q.empty;

  painterengine_gpu_fifo_ram #(
    .DATA_W (PARAM_DATA_WIDTH),
    .DEPTH  (PARAM_FIFO_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (i_wire_clock),
    .i_we    (push_ok && !i_wire_flush),
    .i_waddr (wr_ptr_q),
    .i_wdata (i_wire_data_in),
    .i_raddr (rd_ptr_q),
    .o_rdata (ram_rdata)
  );

  // Next-state for pointers, count, peak and flags; flush overrides all.
  always_comb begin
    count_next = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    peak_d     = peak_q;
    flags_d    = flags_q;
    if (i_wire_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      peak_d   = '0;
      flags_d  = FLAGS_RESET;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      count_d              = count_next;
      peak_d               = (count_next > peak_q) ? count_next : peak_q;
      flags_d.full         = (count_next == DEPTH_CNT);
      flags_d.empty        = (count_next == '0);
      flags_d.almost_full  = (count_next >= i_wire_almost_full_threshold);
      flags_d.almost_empty = (count_next <= i_wire_almost_empty_threshold);
    end
  end

  // State registers.
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      peak_q   <= '0;
      flags_q  <= FLAGS_RESET;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      peak_q   <= peak_d;
      flags_q  <= flags_d;
    end
  end

`ifdef PAINTERENGINE_GPU_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error capture; cleared only by reset or flush.
  always_comb begin
    overflow_d  = overflow_q  | (i_wire_write && flags_q.full);
    underflow_d = underflow_q | (i_wire_read  && flags_q.empty);
    if (i_wire_flush) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  // Error flag registers.
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_wire_overflow  = overflow_q;
  assign o_wire_underflow = underflow_q;
`endif

  // Head word is forced to zero when empty so the output never shows stale RAM.
  assign o_wire_data_out     = flags_q.empty ? '0 : ram_rdata;
  assign o_wire_valid        = !flags_q.empty;
  assign o_wire_data_count   = count_q;
  assign o_wire_peak_count   = peak_q;
  assign o_wire_full         = flags_q.full;
  assign o_wire_almost_full  = flags_q.almost_full;
  assign o_wire_empty        = flags_q.empty;
  assign o_wire_almost_empty = flags_q.almost_empty;

endmodule

// File: tb/tb_painterengine_gpu_sync_fifo.sv
// Testbench for painterengine_gpu_sync_fifo at DEPTH=8, WIDTH=32.
module tb_painterengine_gpu_sync_fifo;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          flush = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [W-1:0]  din = '0;
  logic [CW-1:0] af_th = CW'(6);
  logic [CW-1:0] ae_th = CW'(1);
  logic [W-1:0]  dout;
  logic          valid;
  logic [CW-1:0] cnt;
  logic [CW-1:0] peak;
  logic          full, afull, empty, aempty;
`ifdef PAINTERENGINE_GPU_FIFO_ERR_FLAGS_EN
  logic          ovf, unf;
`endif

  painterengine_gpu_sync_fifo #(
    .PARAM_DATA_WIDTH (W),
    .PARAM_FIFO_DEPTH (D)
  ) dut (
    .i_wire_clock                  (clk),
    .i_wire_resetn                 (resetn),
    .i_wire_flush                  (flush),
    .i_wire_write                  (wr),
    .i_wire_data_in                (din),
    .i_wire_read                   (rd),
    .o_wire_data_out               (dout),
    .o_wire_valid                  (valid),
    .i_wire_almost_full_threshold  (af_th),
    .i_wire_almost_empty_threshold (ae_th),
    .o_wire_data_count             (cnt),
    .o_wire_peak_count             (peak),
    .o_wire_full                   (full),
    .o_wire_almost_full            (afull),
    .o_wire_empty                  (empty),
`ifdef PAINTERENGINE_GPU_FIFO_ERR_FLAGS_EN
    .o_wire_almost_empty           (aempty),
    .o_wire_overflow               (ovf),
    .o_wire_underflow              (unf)
`else
    .o_wire_almost_empty           (aempty)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: a queue of stored words plus watermark and flags.
  logic [W-1:0] mq[$];
  int           m_peak;
  bit           m_af, m_ae, m_ovf, m_unf;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_peak = 0;
    m_af   = 1'b0;
    m_ae   = 1'b1;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic model_edge(input bit w, input bit r, input bit f, input logic [W-1:0] d);
    bit was_full, was_empty;
    int n;
    if (f) begin
      model_reset();
    end else begin
      was_full  = (mq.size() == D);
      was_empty = (mq.size() == 0);
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_unf = 1'b1;
      if (r && !was_empty) void'(mq.pop_front());
      if (w && !was_full)  mq.push_back(d);
      n = mq.size();
      if (n > m_peak) m_peak = n;
      m_af = (n >= int'(af_th));
      m_ae = (n <= int'(ae_th));
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] head;
    int n;
    n = mq.size();
    head = (n != 0) ? mq[0] : '0;
    chk({tag, "/data"},   dout,   head);
    chk({tag, "/count"},  W'(cnt),  W'(n));
    chk({tag, "/peak"},   W'(peak), W'(m_peak));
    chk({tag, "/full"},   W'(full),   W'(n == D));
    chk({tag, "/empty"},  W'(empty),  W'(n == 0));
    chk({tag, "/valid"},  W'(valid),  W'(n != 0));
    chk({tag, "/afull"},  W'(afull),  W'(m_af));
    chk({tag, "/aempty"}, W'(aempty), W'(m_ae));
`ifdef PAINTERENGINE_GPU_FIFO_ERR_FLAGS_EN
    chk({tag, "/ovf"},    W'(ovf),    W'(m_ovf));
    chk({tag, "/unf"},    W'(unf),    W'(m_unf));
`endif
  endtask

  // One clock: drive inputs, let the edge happen, update model, compare.
  task automatic step(input string tag, input bit w, input bit r, input bit f, input logic [W-1:0] d);
    wr = w; rd = r; flush = f; din = d;
    @(posedge clk);
    model_edge(w, r, f, d);
    #1;
    check_all(tag);
    wr = 1'b0; rd = 1'b0; flush = 1'b0;
  endtask

  typedef struct {
    bit           w;
    bit           r;
    logic [W-1:0] d;
    int           exp_cnt;
    logic [W-1:0] exp_head;
    bit           exp_empty;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'hA0, 1, 32'hA0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 32'hA1, 2, 32'hA0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 32'hA2, 3, 32'hA0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'hA3, 4, 32'hA0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 32'h00, 3, 32'hA1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 32'h00, 2, 32'hA2, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 32'h00, 1, 32'hA3, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 32'h00, 0, 32'h00, 1'b1};

    model_reset();
    #12 resetn = 1'b1;
    #1 check_all("reset");

    // Ordered push/pop table.
    for (int i = 0; i < 8; i++) begin
      step("tbl", tbl[i].w, tbl[i].r, 1'b0, tbl[i].d);
      chk($sformatf("tbl%0d/count", i), W'(cnt), W'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d/head", i),  dout, tbl[i].exp_head);
      chk($sformatf("tbl%0d/empty", i), W'(empty), W'(tbl[i].exp_empty));
    end

    // Overfill: ninth push rejected.
    for (int i = 0; i < 9; i++) step("fill9", 1'b1, 1'b0, 1'b0, 32'hB0 + W'(i));
    chk("fill9/full",  W'(full), 32'd1);
    chk("fill9/count", W'(cnt),  32'd8);
    chk("fill9/peak",  W'(peak), 32'd8);
    chk("fill9/head",  dout,     32'hB0);
`ifdef PAINTERENGINE_GPU_FIFO_ERR_FLAGS_EN
    chk("fill9/ovf",   W'(ovf),  32'd1);
`endif
    step("pop_full", 1'b0, 1'b1, 1'b0, '0);
    chk("pop_full/head", dout, 32'hB1);
    for (int i = 0; i < 7; i++) step("drain9", 1'b0, 1'b1, 1'b0, '0);
    chk("drain9/last_count", W'(cnt), 32'd0);

    // Simultaneous read+write at count 3, then at full.
    for (int i = 0; i < 3; i++) step("rw_pre", 1'b1, 1'b0, 1'b0, 32'hC0 + W'(i));
    for (int i = 0; i < 5; i++) begin
      step("rw3", 1'b1, 1'b1, 1'b0, 32'hC3 + W'(i));
      chk("rw3/count", W'(cnt), 32'd3);
      chk("rw3/head",  dout,    32'hC1 + W'(i));
    end
    for (int i = 0; i < 5; i++) step("rw_fill", 1'b1, 1'b0, 1'b0, 32'hD0 + W'(i));
    chk("rw_fill/count", W'(cnt), 32'd8);
    step("rw8", 1'b1, 1'b1, 1'b0, 32'hEE);
    chk("rw8/count", W'(cnt), 32'd7);
    for (int i = 0; i < 7; i++) step("rw_drain", 1'b0, 1'b1, 1'b0, '0);

    // Threshold crossings, AF=6 AE=1, with explicit expectations.
    for (int i = 1; i <= 8; i++) begin
      step("af_fill", 1'b1, 1'b0, 1'b0, 32'hF0 + W'(i));
      chk($sformatf("af_fill%0d/afull", i),  W'(afull),  W'(i >= 6));
      chk($sformatf("af_fill%0d/aempty", i), W'(aempty), W'(i <= 1));
    end
    for (int i = 7; i >= 0; i--) begin
      step("af_drain", 1'b0, 1'b1, 1'b0, '0);
      chk($sformatf("af_drain%0d/afull", i),  W'(afull),  W'(i >= 6));
      chk($sformatf("af_drain%0d/aempty", i), W'(aempty), W'(i <= 1));
    end

    // Flush at count 5 with a concurrent write.
    for (int i = 0; i < 5; i++) step("fl_pre", 1'b1, 1'b0, 1'b0, 32'h50 + W'(i));
    step("flush", 1'b1, 1'b0, 1'b1, 32'hDEAD);
    chk("flush/count", W'(cnt),   32'd0);
    chk("flush/empty", W'(empty), 32'd1);
    chk("flush/peak",  W'(peak),  32'd0);
`ifdef PAINTERENGINE_GPU_FIFO_ERR_FLAGS_EN
    chk("flush/ovf",   W'(ovf),   32'd0);
`endif
    step("post_flush", 1'b0, 1'b0, 1'b0, '0);

    // Read while empty, then 0x55 round trip.
    step("rd_empty", 1'b0, 1'b1, 1'b0, '0);
`ifdef PAINTERENGINE_GPU_FIFO_ERR_FLAGS_EN
    chk("rd_empty/unf", W'(unf), 32'd1);
`endif
    step("push55", 1'b1, 1'b0, 1'b0, 32'h55);
    chk("push55/head", dout, 32'h55);
    step("pop55", 1'b0, 1'b1, 1'b0, '0);
    chk("pop55/empty", W'(empty), 32'd1);

    // Async reset in the middle of a burst.
    for (int i = 0; i < 3; i++) step("burst", 1'b1, 1'b0, 1'b0, 32'h70 + W'(i));
    wr = 1'b1; din = 32'h77;
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    wr = 1'b0;
    @(posedge clk);
    #1 check_all("in_rst");
    #2 resetn = 1'b1;

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int wp;
      bit w, r, f;
      wp = ((i / 50) % 2 == 0) ? 75 : 25;
      w = ($urandom_range(0, 99) < wp);
      r = ($urandom_range(0, 99) < (100 - wp));
      f = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 19) == 0) af_th = CW'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) ae_th = CW'($urandom_range(0, 15));
      step($sformatf("rnd%0d", i), w, r, f, $urandom());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
